// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes RV32I into ALU control/operands and registers them with valid/ready, stall and flush
module alu_issue_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       ALU_Control,
  output logic [XLEN-1:0]  SrcA,
  output logic [XLEN-1:0]  SrcB,
  output logic             is_branch,
  output logic [2:0]       br_funct3,
  output logic             illegal,
  output logic [CNT_W-1:0] issue_count
);
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LUI = 7'b0110111,
                         OP_AUIPC = 7'b0010111, OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011,
                         OP_BR = 7'b1100011;
  logic [6:0] opc;
  logic [2:0] f3;
  logic alt, shift, ar_ill, load;
  logic [3:0] ar_ctl, d_ctl;
  logic [XLEN-1:0] i_imm, s_imm, u_imm, d_a, d_b;
  logic d_br, d_ill;
  logic unused_bits;
  assign unused_bits = ^instr[19:15];
  assign opc = instr[6:0];
  assign f3 = instr[14:12];
  assign alt = instr[30];
  assign i_imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign s_imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
  assign u_imm = {instr[31:12], 12'b0};
  assign shift = f3 == 3'b001 || f3 == 3'b101;
  assign ar_ill = f3 == 3'b010;
  assign ar_ctl = f3 == 3'b000 ? ((opc == OP_R && alt) ? 4'b0001 : 4'b0000) :
                  f3 == 3'b001 ? 4'b0100 :
                  f3 == 3'b100 ? 4'b0101 :
                  f3 == 3'b110 ? 4'b0011 :
                  f3 == 3'b111 ? 4'b0010 :
                  f3 == 3'b011 ? 4'b0110 :
                  f3 == 3'b101 ? (alt ? 4'b1000 : 4'b0111) : 4'b0000;
  always_comb begin
    d_ctl = 4'b0000;
    d_a = '0;
    d_b = '0;
    d_br = 1'b0;
    d_ill = 1'b0;
    case (opc)
      OP_R, OP_I: begin
        d_a = rs1_data;
        d_b = opc == OP_R ? (shift ? {{(XLEN-5){1'b0}}, rs2_data[4:0]} : rs2_data)
                          : (shift ? {{(XLEN-5){1'b0}}, instr[24:20]} : i_imm);
        d_ctl = ar_ill ? 4'b0000 : ar_ctl;
        d_ill = ar_ill;
      end
      OP_LUI: d_b = u_imm;
      OP_AUIPC: begin
        d_a = pc;
        d_b = u_imm;
      end
      OP_LOAD: begin
        d_a = rs1_data;
        d_b = i_imm;
      end
      OP_STORE: begin
        d_a = rs1_data;
        d_b = s_imm;
      end
      OP_BR: begin
        d_a = rs1_data;
        d_b = rs2_data;
        d_br = 1'b1;
        d_ill = f3[2:1] == 2'b01;
        d_ctl = f3[2:1] == 2'b11 ? 4'b0110 : f3[2:1] == 2'b01 ? 4'b0000 : 4'b0001;
      end
      default: d_ill = 1'b1;
    endcase
  end
  assign in_ready = ~out_valid | out_ready;
  assign load = in_valid & in_ready & ~flush;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      ALU_Control <= '0;
      SrcA <= '0;
      SrcB <= '0;
      is_branch <= 1'b0;
      br_funct3 <= '0;
      illegal <= 1'b0;
      issue_count <= '0;
    end else begin
      if (out_valid & out_ready & ~flush) issue_count <= issue_count + CNT_W'(1);
      if (flush) out_valid <= 1'b0;
      else if (load) begin
        out_valid <= 1'b1;
        ALU_Control <= d_ctl;
        SrcA <= d_a;
        SrcB <= d_b;
        is_branch <= d_br;
        br_funct3 <= f3;
        illegal <= d_ill;
      end else if (out_ready) out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: table-driven decode vectors plus stall, flush, wrap and async-reset sequences
module tb_alu_issue_stage;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [31:0] instr = '0, pc = '0, rs1_data = '0, rs2_data = '0;
  logic in_ready, out_valid, is_branch, illegal;
  logic [3:0] ALU_Control;
  logic [31:0] SrcA, SrcB;
  logic [2:0] br_funct3;
  logic [15:0] issue_count;
  int total = 0, bad = 0;
  logic [15:0] exp_cnt;
  int need;

  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .ALU_Control(ALU_Control), .SrcA(SrcA), .SrcB(SrcB),
    .is_branch(is_branch), .br_funct3(br_funct3), .illegal(illegal), .issue_count(issue_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr, pc, rs1, rs2, a, b;
    logic [3:0] ctl;
    logic br, ill, chk_ab;
    logic [2:0] f3;
  } vec_t;
  vec_t v[22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
    instr = i;
    rs1_data = a;
    rs2_data = b;
  endtask

  initial begin
    v[0]  = '{32'h002081B3, 0, 5, 7, 5, 7, 4'h0, 0, 0, 1, 3'd0};
    v[1]  = '{32'h40208133, 0, 9, 4, 9, 4, 4'h1, 0, 0, 1, 3'd0};
    v[2]  = '{32'h41F15093, 0, 32'h80000000, 0, 32'h80000000, 32'h1F, 4'h8, 0, 0, 1, 3'd0};
    v[3]  = '{32'h003110B3, 0, 32'h55, 32'h123, 32'h55, 3, 4'h4, 0, 0, 1, 3'd0};
    v[4]  = '{32'hABCDE0B7, 0, 32'h11, 32'h22, 0, 32'hABCDE000, 4'h0, 0, 0, 1, 3'd0};
    v[5]  = '{32'h00001097, 32'h100, 32'h11, 32'h22, 32'h100, 32'h1000, 4'h0, 0, 0, 1, 3'd0};
    v[6]  = '{32'hFE20AE23, 0, 32'h1000, 32'h22, 32'h1000, 32'hFFFFFFFC, 4'h0, 0, 0, 1, 3'd0};
    v[7]  = '{32'h0020E063, 0, 3, 8, 3, 8, 4'h6, 1, 0, 1, 3'd6};
    v[8]  = '{32'h00208063, 0, 3, 3, 3, 3, 4'h1, 1, 0, 1, 3'd0};
    v[9]  = '{32'h003120B3, 0, 3, 8, 0, 0, 4'h0, 0, 1, 0, 3'd0};
    v[10] = '{32'h0000007F, 32'h200, 3, 8, 0, 0, 4'h0, 0, 1, 1, 3'd0};
    v[11] = '{32'hFFF10093, 0, 32'h10, 0, 32'h10, 32'hFFFFFFFF, 4'h0, 0, 0, 1, 3'd0};
    v[12] = '{32'h40010093, 0, 32'h10, 0, 32'h10, 32'h400, 4'h0, 0, 0, 1, 3'd0};
    v[13] = '{32'h00513093, 0, 32'h10, 0, 32'h10, 5, 4'h6, 0, 0, 1, 3'd0};
    v[14] = '{32'h0F017093, 0, 32'hFF, 0, 32'hFF, 32'hF0, 4'h2, 0, 0, 1, 3'd0};
    v[15] = '{32'h403150B3, 0, 32'hF0000000, 32'h24, 32'hF0000000, 4, 4'h8, 0, 0, 1, 3'd0};
    v[16] = '{32'h003140B3, 0, 6, 3, 6, 3, 4'h5, 0, 0, 1, 3'd0};
    v[17] = '{32'h003160B3, 0, 6, 3, 6, 3, 4'h3, 0, 0, 1, 3'd0};
    v[18] = '{32'h00812083, 0, 32'h40, 0, 32'h40, 8, 4'h0, 0, 0, 1, 3'd0};
    v[19] = '{32'h0020A063, 0, 3, 8, 0, 0, 4'h0, 1, 1, 0, 3'd2};
    v[20] = '{32'h00415093, 0, 32'h80, 0, 32'h80, 4, 4'h7, 0, 0, 1, 3'd0};
    v[21] = '{32'h00313093, 0, 32'h7, 0, 32'h7, 3, 4'h6, 0, 0, 1, 3'd0};
    #1;
    chk("rst out_valid", out_valid, 0);
    chk("rst in_ready", in_ready, 1);
    chk("rst ctl", ALU_Control, 0);
    chk("rst srca", SrcA, 0);
    chk("rst srcb", SrcB, 0);
    chk("rst branch", is_branch, 0);
    chk("rst f3", br_funct3, 0);
    chk("rst illegal", illegal, 0);
    chk("rst count", issue_count, 0);
    #10 rst_n = 1'b1;
    exp_cnt = 0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 22; i++) begin
      drive(v[i].instr, v[i].rs1, v[i].rs2);
      pc = v[i].pc;
      step();
      chk($sformatf("v%0d valid", i), out_valid, 1);
      chk($sformatf("v%0d ctl", i), ALU_Control, v[i].ctl);
      chk($sformatf("v%0d branch", i), is_branch, v[i].br);
      chk($sformatf("v%0d illegal", i), illegal, v[i].ill);
      if (v[i].chk_ab) begin
        chk($sformatf("v%0d srca", i), SrcA, v[i].a);
        chk($sformatf("v%0d srcb", i), SrcB, v[i].b);
      end
      if (v[i].br) chk($sformatf("v%0d f3", i), br_funct3, v[i].f3);
      chk($sformatf("v%0d count", i), issue_count, exp_cnt);
      exp_cnt++;
    end
    pc = 0;
    in_valid = 1'b0;
    step();
    chk("drain valid", out_valid, 0);
    chk("drain count", issue_count, exp_cnt);
    // stall: A held while B waits, then A consumed and B loaded on the same edge
    drive(32'h002081B3, 1, 2);
    in_valid = 1'b1;
    out_ready = 1'b0;
    step();
    chk("stall load valid", out_valid, 1);
    drive(32'h40208133, 10, 3);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall valid", out_valid, 1);
      chk("stall srca", SrcA, 1);
      chk("stall srcb", SrcB, 2);
      chk("stall ctl", ALU_Control, 0);
      chk("stall in_ready", in_ready, 0);
      chk("stall count", issue_count, exp_cnt);
    end
    out_ready = 1'b1;
    #1;
    chk("unstall in_ready", in_ready, 1);
    step();
    exp_cnt++;
    chk("swap valid", out_valid, 1);
    chk("swap ctl", ALU_Control, 1);
    chk("swap srca", SrcA, 10);
    chk("swap count", issue_count, exp_cnt);
    in_valid = 1'b0;
    step();
    exp_cnt++;
    chk("consume valid", out_valid, 0);
    chk("consume count", issue_count, exp_cnt);
    // flush beats consume and load
    drive(32'h002081B3, 4, 4);
    in_valid = 1'b1;
    step();
    chk("pre-flush valid", out_valid, 1);
    drive(32'h40208133, 8, 1);
    flush = 1'b1;
    step();
    chk("flush valid", out_valid, 0);
    chk("flush count", issue_count, exp_cnt);
    flush = 1'b0;
    in_valid = 1'b0;
    step();
    chk("post-flush valid", out_valid, 0);
    chk("post-flush count", issue_count, exp_cnt);
    // stream up to 0xFFFF, then wrap
    need = 16'hFFFF - exp_cnt;
    drive(32'h002081B3, 1, 1);
    in_valid = 1'b1;
    repeat (need + 1) step();
    exp_cnt = exp_cnt + need[15:0];
    chk("count max", issue_count, exp_cnt);
    chk("stream valid", out_valid, 1);
    step();
    exp_cnt++;
    chk("count wrap", issue_count, exp_cnt);
    step();
    exp_cnt++;
    chk("count after wrap", issue_count, exp_cnt);
    out_ready = 1'b0;
    drive(32'h00001097, 0, 0);
    pc = 32'h55;
    step();
    chk("pre-reset valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async valid", out_valid, 0);
    chk("async count", issue_count, 0);
    chk("async srca", SrcA, 0);
    chk("async in_ready", in_ready, 1);
    in_valid = 1'b0;
    #5 rst_n = 1'b1;
    step();
    chk("post-reset valid", out_valid, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
